// File: rtl/decode_hazard_ctrl.sv
// Decode-stage hazard/bubble controller: load-use stalls, redirect flushes.
// Ports: clk, rst (sync, active-high); D-stage operand/dest info and
//   redirect_x in; pc_hold, fd_hold, fd_kill, dx_nop, stalled out.
//   Optional HAZARD_PERF_CNT_EN adds stall_cycles / flush_cycles counters.
module decode_hazard_ctrl #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int FLUSH_CYCLES     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_d,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic       rs1_used_d,
  input  logic       rs2_used_d,
  input  logic [4:0] rd_d,
  input  logic       reg_we_d,
  input  logic       is_load_d,
  input  logic       redirect_x,
  output logic       pc_hold,
  output logic       fd_hold,
  output logic       fd_kill,
  output logic       dx_nop,
  output logic       stalled
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] STALL_INIT =
    2'(LOAD_USE_BUBBLES - 1);
  localparam logic [1:0] FLUSH_INIT =
    2'(FLUSH_CYCLES - 1);
  localparam bit MULTI_STALL = LOAD_USE_BUBBLES > 1;
  localparam bit MULTI_FLUSH = FLUSH_CYCLES > 1;

  state_t     state;
  state_t     state_n;
  logic [1:0] cnt;
  logic [1:0] cnt_n;

  logic [4:0] x_rd;
  logic       x_we;
  logic       x_load;

  logic       src_hit;
  logic       hazard;

  // Only a load in X can't be forwarded in time; x0 is never a real dep.
  assign src_hit =
    (rs1_used_d & (rs1_d == x_rd)) |
    (rs2_used_d & (rs2_d == x_rd));

  assign hazard =
    x_load & x_we & (x_rd != 5'd0) &
    valid_d & src_hit;

  always_comb begin
    pc_hold = 1'b0;
    fd_hold = 1'b0;
    fd_kill = 1'b0;
    dx_nop  = 1'b0;
    stalled = 1'b0;
    state_n = state;
    cnt_n   = cnt;
    if (!rst) begin
      stalled = (state == STALL);
      if (redirect_x) begin
        // Wrong-path squash wins over any stall in progress.
        fd_kill = 1'b1;
        dx_nop  = 1'b1;
        if (MULTI_FLUSH) begin
          state_n = FLUSH;
          cnt_n   = FLUSH_INIT;
        end else begin
          state_n = RUN;
          cnt_n   = 2'd0;
        end
      end else begin
        unique case (state)
          RUN: begin
            if (hazard) begin
              pc_hold = 1'b1;
              fd_hold = 1'b1;
              dx_nop  = 1'b1;
              if (MULTI_STALL) begin
                state_n = STALL;
                cnt_n   = STALL_INIT;
              end
            end
          end
          STALL: begin
            pc_hold = 1'b1;
            fd_hold = 1'b1;
            dx_nop  = 1'b1;
            cnt_n   = cnt - 2'd1;
            if (cnt <= 2'd1) begin
              state_n = RUN;
              cnt_n   = 2'd0;
            end
          end
          FLUSH: begin
            fd_kill = 1'b1;
            dx_nop  = 1'b1;
            cnt_n   = cnt - 2'd1;
            if (cnt <= 2'd1) begin
              state_n = RUN;
              cnt_n   = 2'd0;
            end
          end
          default: begin
            state_n = RUN;
            cnt_n   = 2'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Tracks what enters X; a bubble leaves nothing to depend on.
  always_ff @(posedge clk) begin
    if (rst || dx_nop) begin
      x_rd   <= 5'd0;
      x_we   <= 1'b0;
      x_load <= 1'b0;
    end else begin
      x_rd   <= rd_d;
      x_we   <= reg_we_d & valid_d;
      x_load <= is_load_d & valid_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_cycles <= 32'd0;
    end else begin
      if (pc_hold)
        stall_cycles <= stall_cycles + 32'd1;
      if (fd_kill)
        flush_cycles <= flush_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/decode_hazard_ctrl.md
# decode_hazard_ctrl

Hazard and bubble controller for the decode stage of the pipelined RISC-V core. It sits directly upstream of the D→X control pipeline register and drives that register's NOP-insertion input. It also drives the hold and kill controls for the PC and F/D registers. Internally it tracks the destination of the instruction in X, detects load-use hazards and sequences multi-cycle stalls and redirect flushes with a small FSM.

## Interface
Parameters:
- LOAD_USE_BUBBLES, default 1: bubbles inserted per load-use hazard; legal range 1–3.
- FLUSH_CYCLES, default 1: cycles of wrong-path kill after a redirect; legal range 1–3.

Ports:
- clk  input  1  core clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- valid_d  input  1  D holds a real instruction.
- rs1_d, rs2_d  input  5 each  source register indices in D.
- rs1_used_d, rs2_used_d  input  1 each  the instruction in D reads that source.
- rd_d  input  5  destination index in D.
- reg_we_d  input  1  the instruction in D writes rd.
- is_load_d  input  1  the instruction in D is a load.
- redirect_x  input  1  X resolved a taken branch, jal, jalr or trap; the PC is redirected.
- pc_hold  output  1  PC keeps its value.
- fd_hold  output  1  F/D register keeps its value.
- fd_kill  output  1  F/D contents are squashed to NOP.
- dx_nop  output  1  to the D→X register NOP input; X receives a bubble next cycle.
- stalled  output  1  FSM is in STALL, for debug.

## Operation
- Tracking registers x_rd[4:0], x_we and x_load describe the instruction entering X.
  - Each cycle they load {rd_d, reg_we_d & valid_d, is_load_d & valid_d}.
  - If dx_nop is 1 that cycle, they load {0, 0, 0} instead.
- Hazard condition: x_load & x_we & (x_rd != 0) & valid_d & ((rs1_used_d & rs1_d == x_rd) | (rs2_used_d & rs2_d == x_rd)).
- Register x0 never causes a hazard. All non-load RAW hazards are left to forwarding.
- FSM has three states: RUN, STALL and FLUSH. The 2-bit counter cnt is used by STALL and FLUSH.
- RUN:
  - redirect_x → fd_kill=1, dx_nop=1. Go to FLUSH with cnt=FLUSH_CYCLES-1, or stay in RUN if FLUSH_CYCLES=1.
  - Otherwise, hazard → pc_hold=fd_hold=dx_nop=1. Go to STALL with cnt=LOAD_USE_BUBBLES-1, or stay in RUN if LOAD_USE_BUBBLES=1.
  - Otherwise all outputs are 0.
- STALL:
  - pc_hold=fd_hold=dx_nop=1 and stalled=1.
  - cnt decrements; when cnt==0, return to RUN next cycle.
  - The hazard condition is not re-evaluated in this state.
- FLUSH:
  - fd_kill=dx_nop=1.
  - cnt decrements; when cnt==0, return to RUN.
- Priority: redirect_x beats hazard in every state.
  - In STALL or FLUSH, a redirect_x forces fd_kill=dx_nop=1 and pc_hold=fd_hold=0.
  - It then enters FLUSH with cnt reloaded to FLUSH_CYCLES-1, or goes to RUN if FLUSH_CYCLES=1.
- When valid_d=0, no hazard is raised.

## Timing
- Outputs are combinational from the current D inputs, redirect_x, state and the tracking registers. Zero-cycle decision latency.
- A hazard seen in cycle t gives a bubble in X at t+1. The dependent instruction enters X at t+LOAD_USE_BUBBLES+1.
- A redirect in cycle t kills the D instruction in cycle t. The first correct-path fetch occupies D at t+FLUSH_CYCLES.
- While rst=1, all outputs are forced to 0.
- Reset values (next edge): state=RUN, cnt=0, x_rd=0, x_we=0, x_load=0.
- A reset asserted mid-STALL or mid-FLUSH aborts it; after rst deasserts the FSM resumes in RUN.
- Back-to-back loads with dependent chains are each detected independently after returning to RUN.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - Adds outputs stall_cycles[31:0] and flush_cycles[31:0].
  - stall_cycles increments every cycle pc_hold=1. flush_cycles increments every cycle fd_kill=1.
  - Both clear on rst and wrap modulo 2^32.
- HAZARD_PERF_CNT_EN undefined: the ports and counters do not exist. Functional behaviour is otherwise identical.

## Test plan
- Load-use: lw x5 followed by add x6,x5,x1 (LOAD_USE_BUBBLES=1) → pc_hold/fd_hold/dx_nop high for exactly 1 cycle; add enters X one cycle late.
- x0 and unused source: lw x0 followed by add x1,x0,x0; and lw x5 followed by lui x5 (rs unused) → no stall in either case.
- Multi-bubble: LOAD_USE_BUBBLES=3, lw x7 followed by sw using x7 → stalled high for cycles t+1..t+2; hold asserted for 3 cycles total; then RUN.
- Redirect over stall: redirect_x pulsed in the same cycle as a hazard → fd_kill=dx_nop=1, pc_hold=0; with FLUSH_CYCLES=2, fd_kill is high for 2 cycles.
- Reset mid-operation: rst asserted during STALL with cnt=1 → outputs 0 while rst=1; first cycle after deassert is RUN with x_* cleared and no spurious hazard.
- Counters (HAZARD_PERF_CNT_EN): 3 load-use stalls and 2 redirects with defaults → stall_cycles=3, flush_cycles=2; rst → both 0.
